// File: rtl/fsm_arb.sv
// Two-requester round-robin arbiter that issues commands to an external FSM and returns its next state.
// Optional grant locking is compiled in with FSM_ARB_LOCK_EN.
module fsm_arb #(
    parameter logic [63:0] HOLD_TABLE = 64'h1001_0020_1000_0401
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] cmd0,
    input  logic [3:0] cmd1,
`ifdef FSM_ARB_LOCK_EN
    input  logic [1:0] lock,
`endif
    output logic [1:0] gnt,
    output logic [3:0] fsm_y_in,
    input  logic [3:0] fsm_y_out,
    output logic       resp_valid,
    output logic       resp_id,
    output logic [3:0] resp_state
);

    logic       r_last_id;
    logic       r_resp_valid;
    logic       r_resp_id;
    logic [1:0] w_gnt;
    logic       w_any_gnt;
    logic       w_gnt_id;
    logic       w_lock_hold;
    logic [3:0] w_hold_idx;

`ifdef FSM_ARB_LOCK_EN
    logic [1:0] r_lock_cnt;

    // r_last_id always names the most recent winner, so it also names the lock owner
    always_comb begin
        w_lock_hold = r_resp_valid && req[r_last_id] && lock[r_last_id] && (r_lock_cnt != 2'd3);
    end
`else
    always_comb begin
        w_lock_hold = 1'b0;
    end
`endif

    always_comb begin
        w_gnt = 2'b00;
        if (!rst) begin
            if (w_lock_hold) begin
                w_gnt = r_last_id ? 2'b10 : 2'b01;
            end else if (req == 2'b11) begin
                w_gnt = r_last_id ? 2'b01 : 2'b10;
            end else begin
                w_gnt = req;
            end
        end
    end

    assign w_any_gnt = |w_gnt;
    assign w_gnt_id  = w_gnt[1];

    // An unknown state from the FSM falls back to hold entry 0 in simulation
    assign w_hold_idx = ((^fsm_y_out) === 1'bx) ? 4'd0 : fsm_y_out;

    always_comb begin
        fsm_y_in = HOLD_TABLE[{w_hold_idx, 2'b00} +: 4];
        if (w_any_gnt) begin
            fsm_y_in = w_gnt_id ? cmd1 : cmd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_id    <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
        end else begin
            r_resp_valid <= w_any_gnt;
            if (w_any_gnt) begin
                r_resp_id <= w_gnt_id;
            end
            if (w_any_gnt && !w_lock_hold) begin
                r_last_id <= w_gnt_id;
            end
        end
    end

`ifdef FSM_ARB_LOCK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_cnt <= 2'd0;
        end else if (w_lock_hold) begin
            r_lock_cnt <= r_lock_cnt + 2'd1;
        end else begin
            r_lock_cnt <= 2'd0;
        end
    end
`endif

    assign gnt        = w_gnt;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_state = fsm_y_out;

endmodule

// File: doc/fsm_arb.md
FSM_ARB -- requirements
Module: fsm_arb

Interface
REQ-001 Parameter: HOLD_TABLE, default 64'h1001_0020_1000_0401, 4-bit hold code per FSM state; state s uses bits [4s+3:4s].
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  2  per-requester command request; req[i] is held until gnt[i].
REQ-005 Port: cmd0  input  4  requester 0 command; the y_in code to apply.
REQ-006 Port: cmd1  input  4  requester 1 command.
REQ-007 Port: lock  input  2  per-requester grant-hold request; present only with FSM_ARB_LOCK_EN.
REQ-008 Port: gnt  output  2  one-hot grant, same cycle as the request; at most one bit set.
REQ-009 Port: fsm_y_in  output  4  drives y_in of the fsm instance.
REQ-010 Port: fsm_y_out  input  4  current state from the fsm instance.
REQ-011 Port: resp_valid  output  1  response strobe, one cycle after a grant.
REQ-012 Port: resp_id  output  1  requester index of the response.
REQ-013 Port: resp_state  output  4  FSM state after the granted command.

Function
REQ-014 The arbiter shall grant one requester per cycle; the grant decision shall be combinational from req, the pointer and the lock state.
REQ-015 Round-robin: register last_id; on contention, grant the requester other than last_id; on a single request, grant that requester.
REQ-016 last_id shall update to the granted index on every grant edge and shall hold when there is no grant.
REQ-017 Granted cycle: fsm_y_in = cmd of the granted requester.
REQ-018 No grant: fsm_y_in = HOLD_TABLE[4*fsm_y_out +: 4]; the FSM stays in its current state.
REQ-019 resp_valid shall be a register set in the cycle after any grant, with resp_id registered alongside.
REQ-020 resp_state = fsm_y_out, combinational, valid whenever resp_valid=1.
REQ-021 Back-to-back grants on consecutive cycles shall be supported; response latency is fixed at 1 cycle with no bubbles.
REQ-022 fsm_y_out containing X/Z shall select hold code 0.

Reset
REQ-023 While rst=1: gnt=0, resp_valid=0, resp_id=0, last_id=1 (requester 0 wins the first contention), lock counter=0.
REQ-024 While rst=1, fsm_y_in shall follow the hold path.
REQ-025 Asserting rst mid-operation shall drop any pending response; after release, no response shall be issued for the pre-reset grant.

Configuration
REQ-026 Macro FSM_ARB_LOCK_EN defined: if the granted requester i holds req[i] and lock[i], it shall be granted again the next cycle regardless of the other request, and last_id shall hold.
REQ-027 Lock limit, with FSM_ARB_LOCK_EN: a 2-bit counter shall cap a locked run at 4 consecutive grants; the 5th cycle shall go to the other requester if it requests. The counter shall clear on any non-locked grant or idle cycle.
REQ-028 FSM_ARB_LOCK_EN undefined: the lock port, counter and lock logic shall be absent; pure round-robin.

Verification
REQ-029 After reset, FSM in state 0; req=01, cmd0=0000 -> gnt=01, fsm_y_in=0000; next cycle resp_valid=1, resp_id=0, resp_state=3.
REQ-030 req=11 held 4 cycles -> gnt sequence 01,10,01,10; four responses with alternating resp_id, each 1 cycle late.
REQ-031 Idle 10 cycles in state 9 -> fsm_y_in=0010 every cycle; fsm_y_out stays 9; resp_valid=0.
REQ-032 rst asserted in the cycle after a grant -> resp_valid=0 immediately and stays 0 after release; next contention grants requester 0.
REQ-033 FSM_ARB_LOCK_EN, req=11, lock=01 held -> gnt=01 for 4 cycles, then gnt=10.
REQ-034 Without FSM_ARB_LOCK_EN, same stimulus as REQ-033 minus lock -> strict alternation.
